// File: rtl/word_byte_fifo.sv
// Word-in, byte-out FIFO: 16-bit words written into a dual-port RAM, drained
// low byte first through a one-word holding register with valid/ready handshake.
module word_byte_fifo #(
  parameter int unsigned AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          we,
  input  logic [15:0]   wd,
  input  logic          re,
  output logic [7:0]    rd,
  output logic          rd_valid,
  output logic          empty,
  output logic          full,
  output logic          ovf,
  output logic [AW+1:0] bcount
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned BW    = AW + 2;

  typedef enum logic [1:0] {IDLE, LO, HI} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] wcount_q, wcount_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   hold_q;
  logic          wr_acc;
  logic          load;
  logic [15:0]   mem [DEPTH];

  assign full = (wcount_q == CW'(DEPTH));

  // Next-state: clr dominates; full is judged on the pre-edge word count.
  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    wcount_d = wcount_q;
    ovf_d    = ovf_q;
    wr_acc   = 1'b0;
    load     = 1'b0;
    if (clr) begin
      state_d  = IDLE;
      wptr_d   = '0;
      rptr_d   = '0;
      wcount_d = '0;
      ovf_d    = 1'b0;
    end else begin
      wr_acc = we && !full;
      if (we && full) ovf_d = 1'b1;
      unique case (state_q)
        IDLE: if (wcount_q != '0) begin
          load    = 1'b1;
          state_d = LO;
        end
        LO: if (re) state_d = HI;
        HI: if (re) begin
          if (wcount_q != '0) begin
            load    = 1'b1;
            state_d = LO;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
      if (wr_acc) wptr_d = wptr_q + AW'(1);
      if (load)   rptr_d = rptr_q + AW'(1);
      wcount_d = wcount_q + CW'(wr_acc) - CW'(load);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wptr_q   <= '0;
      rptr_q   <= '0;
      wcount_q <= '0;
      ovf_q    <= 1'b0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      wcount_q <= wcount_d;
      ovf_q    <= ovf_d;
      if (clr)       hold_q <= '0;
      else if (load) hold_q <= mem[rptr_q];
    end
  end

  // Storage array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr_q] <= wd;
  end

  // In IDLE the high byte of the last loaded word stays on rd.
  assign rd       = (state_q == LO) ? hold_q[7:0] : hold_q[15:8];
  assign rd_valid = (state_q != IDLE);
  assign ovf      = ovf_q;
  assign bcount   = {wcount_q, 1'b0} + ((state_q == LO) ? BW'(2) :
                                        (state_q == HI) ? BW'(1) : BW'(0));
  assign empty    = (bcount == '0);

endmodule
